// File: rtl/i2s_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_clk_gen
//  Purpose  : Audio bit/word clock generator. One phase-locked counter chain
//             (pcnt inside a bit, bcnt inside a frame) produces BCLK, LRCK
//             and single-cycle strobes. LRCK edges always coincide with BCLK
//             falling edges.
//  Ports    : clk_12Mhz  - master clock (12.288 MHz)
//             reset_n    - asynchronous active-low reset
//             en         - synchronous run enable
//             i2s_mode   - 1 = I2S framing, 0 = left-justified
//             bclk       - bit clock, 50 % duty
//             lrck       - word select (0 = left, 1 = right)
//             rx_stb     - bclk rises at the next edge (sample point)
//             tx_stb     - bclk falls at the next edge (drive point)
//             frame_stb  - next edge starts a new frame
//             chan       - current slot channel
//             bit_idx    - bit position inside the current slot
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_clk_gen #(
    parameter  int BCLK_DIV   = 8,
    parameter  int FRAME_BITS = 32,
    localparam int HALF       = FRAME_BITS / 2,
    localparam int IDXW       = (HALF > 1) ? $clog2(HALF) : 1
) (
    input  logic            clk_12Mhz,
    input  logic            reset_n,
    input  logic            en,
    input  logic            i2s_mode,
    output logic            bclk,
    output logic            lrck,
    output logic            rx_stb,
    output logic            tx_stb,
    output logic            frame_stb,
    output logic            chan,
    output logic [IDXW-1:0] bit_idx
);

    localparam int PW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(FRAME_BITS);

    localparam logic [PW-1:0] C_P_LAST = PW'(BCLK_DIV - 1);
    localparam logic [PW-1:0] C_P_HIGH = PW'(BCLK_DIV / 2);
    localparam logic [PW-1:0] C_P_RISE = PW'(BCLK_DIV / 2 - 1);
    localparam logic [BW-1:0] C_B_LAST = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] C_HALF   = BW'(HALF);
    localparam logic [BW-1:0] C_HALF_M1 = BW'(HALF - 1);

    // Elaboration-time parameter checks
    if ((BCLK_DIV < 2) || ((BCLK_DIV % 2) != 0)) begin : g_bad_bclk_div
        $error("i2s_clk_gen: BCLK_DIV must be even and >= 2");
    end
    if ((FRAME_BITS < 4) || ((FRAME_BITS % 2) != 0)) begin : g_bad_frame_bits
        $error("i2s_clk_gen: FRAME_BITS must be even and >= 4");
    end

    logic [PW-1:0] r_pcnt;
    logic [BW-1:0] r_bcnt;
    logic          r_mode;

    logic [PW-1:0] w_pcnt_nxt;
    logic [BW-1:0] w_bcnt_nxt;
    logic          w_mode_nxt;
    logic          w_chan_nxt;
    logic          w_lrck_lj;
    logic          w_lrck_i2s;

    // Next counter state; a stop forces the chain back to (0,0) so the
    // first frame after re-enable is complete and aligned.
    always_comb begin
        w_pcnt_nxt = '0;
        w_bcnt_nxt = '0;
        if (en) begin
            if (r_pcnt == C_P_LAST) begin
                w_pcnt_nxt = '0;
                w_bcnt_nxt = (r_bcnt == C_B_LAST) ? '0 : r_bcnt + BW'(1);
            end else begin
                w_pcnt_nxt = r_pcnt + PW'(1);
                w_bcnt_nxt = r_bcnt;
            end
        end
    end

    // The mode only changes while stopped or on the frame boundary, where
    // both framings give lrck=0, so a switch never produces a short pulse.
    always_comb begin
        w_mode_nxt = (!en || frame_stb) ? i2s_mode : r_mode;
        w_chan_nxt = (w_bcnt_nxt >= C_HALF);
        w_lrck_lj  = w_chan_nxt;
        // ((bcnt+1) mod FRAME_BITS) >= HALF without a wider adder
        w_lrck_i2s = (w_bcnt_nxt >= C_HALF_M1) && (w_bcnt_nxt != C_B_LAST);
    end

    // Outputs are computed from the next counter state so the registered
    // values always describe the counters held in the same cycle.
    always_ff @(posedge clk_12Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_pcnt    <= '0;
            r_bcnt    <= '0;
            r_mode    <= 1'b0;
            bclk      <= 1'b0;
            lrck      <= 1'b0;
            rx_stb    <= 1'b0;
            tx_stb    <= 1'b0;
            frame_stb <= 1'b0;
            chan      <= 1'b0;
            bit_idx   <= '0;
        end else begin
            r_pcnt    <= w_pcnt_nxt;
            r_bcnt    <= w_bcnt_nxt;
            r_mode    <= w_mode_nxt;
            bclk      <= en && (w_pcnt_nxt >= C_P_HIGH);
            lrck      <= en && (w_mode_nxt ? w_lrck_i2s : w_lrck_lj);
            rx_stb    <= en && (w_pcnt_nxt == C_P_RISE);
            tx_stb    <= en && (w_pcnt_nxt == C_P_LAST);
            frame_stb <= en && (w_pcnt_nxt == C_P_LAST) && (w_bcnt_nxt == C_B_LAST);
            chan      <= en && w_chan_nxt;
            bit_idx   <= en ? IDXW'(w_chan_nxt ? w_bcnt_nxt - C_HALF : w_bcnt_nxt) : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_clk_gen
//  Purpose  : Scoreboard bench for i2s_clk_gen. Two instances (defaults and
//             BCLK_DIV=2/FRAME_BITS=64) share the stimulus. A frame-position
//             reference model pushes expected outputs per edge; a monitor
//             pops and compares on the falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_clk_gen;

    localparam int BD_A = 8;
    localparam int FB_A = 32;
    localparam int BD_B = 2;
    localparam int FB_B = 64;

    typedef struct packed {
        logic       bclk;
        logic       lrck;
        logic       rx;
        logic       tx;
        logic       fr;
        logic       chan;
        logic [7:0] idx;
    } exp_t;

    logic clk      = 1'b0;
    logic reset_n  = 1'b0;
    logic en       = 1'b0;
    logic i2s_mode = 1'b0;

    logic       bclk_a, lrck_a, rx_a, tx_a, fr_a, chan_a;
    logic [3:0] idx_a;
    logic       bclk_b, lrck_b, rx_b, tx_b, fr_b, chan_b;
    logic [4:0] idx_b;

    int checks = 0;
    int errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // Reference model state: position inside the frame in master clocks,
    // whether the last edge ran, and the framing mode in force.
    int t_m[2]   = '{0, 0};
    bit act_m[2] = '{1'b0, 1'b0};
    bit mode_m[2] = '{1'b0, 1'b0};

    i2s_clk_gen #(.BCLK_DIV(BD_A), .FRAME_BITS(FB_A)) dut_a (
        .clk_12Mhz (clk),
        .reset_n   (reset_n),
        .en        (en),
        .i2s_mode  (i2s_mode),
        .bclk      (bclk_a),
        .lrck      (lrck_a),
        .rx_stb    (rx_a),
        .tx_stb    (tx_a),
        .frame_stb (fr_a),
        .chan      (chan_a),
        .bit_idx   (idx_a)
    );

    i2s_clk_gen #(.BCLK_DIV(BD_B), .FRAME_BITS(FB_B)) dut_b (
        .clk_12Mhz (clk),
        .reset_n   (reset_n),
        .en        (en),
        .i2s_mode  (i2s_mode),
        .bclk      (bclk_b),
        .lrck      (lrck_b),
        .rx_stb    (rx_b),
        .tx_stb    (tx_b),
        .frame_stb (fr_b),
        .chan      (chan_b),
        .bit_idx   (idx_b)
    );

    always #5 clk = ~clk;

    function automatic exp_t predict(int bd, int fb, int tt, bit a, bit m);
        exp_t e;
        int bitn;
        int ph;
        int half;
        e    = '0;
        bitn = tt / bd;
        ph   = tt % bd;
        half = fb / 2;
        if (a) begin
            e.bclk = (ph >= bd / 2);
            e.lrck = m ? (((bitn + 1) % fb) >= half) : (bitn >= half);
            e.rx   = (ph == bd / 2 - 1);
            e.tx   = (ph == bd - 1);
            e.fr   = e.tx && (bitn == fb - 1);
            e.chan = (bitn >= half);
            e.idx  = 8'(bitn % half);
        end
        return e;
    endfunction

    task automatic model_step(input int k, input int bd, input int fb, output exp_t e);
        bit frame_edge;
        frame_edge = act_m[k] && (t_m[k] == bd * fb - 1);
        if (!en || frame_edge) mode_m[k] = i2s_mode;
        if (!en) begin
            t_m[k]   = 0;
            act_m[k] = 1'b0;
        end else begin
            t_m[k]   = (t_m[k] + 1) % (bd * fb);
            act_m[k] = 1'b1;
        end
        e = predict(bd, fb, t_m[k], act_m[k], mode_m[k]);
    endtask

    always @(negedge reset_n) begin
        for (int k = 0; k < 2; k++) begin
            t_m[k]    = 0;
            act_m[k]  = 1'b0;
            mode_m[k] = 1'b0;
        end
        q_a.delete();
        q_b.delete();
    end

    always @(posedge clk) begin
        exp_t ea;
        exp_t eb;
        if (!reset_n) begin
            ea = '0;
            eb = '0;
        end else begin
            model_step(0, BD_A, FB_A, ea);
            model_step(1, BD_B, FB_B, eb);
        end
        q_a.push_back(ea);
        q_b.push_back(eb);
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (q_a.size() > 0) begin
            e   = q_a.pop_front();
            got = {bclk_a, lrck_a, rx_a, tx_a, fr_a, chan_a, 8'(idx_a)};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL dut_a t=%0t got bclk/lrck/rx/tx/fr/chan=%b idx=%0d required %b idx=%0d",
                         $time, got[13:8], got.idx, e[13:8], e.idx);
            end
        end
        if (q_b.size() > 0) begin
            e   = q_b.pop_front();
            got = {bclk_b, lrck_b, rx_b, tx_b, fr_b, chan_b, 8'(idx_b)};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL dut_b t=%0t got bclk/lrck/rx/tx/fr/chan=%b idx=%0d required %b idx=%0d",
                         $time, got[13:8], got.idx, e[13:8], e.idx);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset is always asserted between edges, away from the monitor sample
    task automatic pulse_reset(input bit check_now);
        logic [13:0] both;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        if (check_now) begin
            both = {bclk_a, lrck_a, rx_a, tx_a, fr_a, chan_a, idx_a != 4'd0,
                    bclk_b, lrck_b, rx_b, tx_b, fr_b, chan_b, idx_b != 5'd0};
            checks++;
            if (both !== 14'd0) begin
                errors++;
                $display("FAIL async_reset got %b required 0", both);
            end
        end
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        int off;
        off = 0;
        // Defaults, left-justified, continuous run
        run(3);
        reset_n = 1'b1;
        en      = 1'b1;
        run(1024);

        // I2S from reset: mode is latched while stopped
        i2s_mode = 1'b1;
        en       = 1'b0;
        pulse_reset(1'b0);
        run(2);
        en = 1'b1;
        run(300);

        // Mode change mid-frame applies only after the next frame boundary
        i2s_mode = 1'b0;
        run(600);
        i2s_mode = 1'b1;
        run(90);

        // Stop for 5 cycles, then resume
        en = 1'b0;
        run(5);
        en = 1'b1;
        run(300);

        // Asynchronous reset mid-bit
        pulse_reset(1'b1);
        run(260);

        // Randomised en / mode activity
        for (int i = 0; i < 2000; i++) begin
            if (off > 0) begin
                en = 1'b0;
                off--;
            end else if ($urandom_range(0, 149) == 0) begin
                en  = 1'b0;
                off = $urandom_range(0, 6);
            end else begin
                en = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) i2s_mode = ~i2s_mode;
            run(1);
        end
        en = 1'b1;
        run(3);

        checks++;
        if ((q_a.size() + q_b.size()) > 1 * 2) begin
            errors++;
            $display("FAIL queue_drain got %0d pending required <= 2", q_a.size() + q_b.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
